// File: rtl/hazard_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : hazard_controller
// Purpose : Pipeline stall/flush control for load-use, taken branches and
//           multi-cycle MUL/DIV waits, with a stall counter and wait timeout.
// Rev     : 1.0  initial release
// ============================================================================
module hazard_controller #(
  parameter int MD_TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_ex_rd,
  input  logic        id_ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic        ex_md_valid,
  input  logic        md_done,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        md_start,
  output logic        md_timeout,
  output logic [15:0] stall_count
);

  localparam int WW = (MD_TIMEOUT > 0) ? $clog2(MD_TIMEOUT + 1) : 1;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [WW-1:0]  wait_cnt;
  logic [WW-1:0]  wait_cnt_next;
  logic           timeout_hit;
  logic           load_use;
  logic           run_mode;
  logic           md_allowed;

  assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                    ((id_ex_rd == id_rs1) || (id_ex_rd == id_rs2));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      md_timeout  <= 1'b0;
      stall_count <= 16'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (timeout_hit) begin
        md_timeout <= 1'b1;
      end
      if (!pc_write && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    md_start      = 1'b0;
    state_next    = state;
    wait_cnt_next = wait_cnt;
    timeout_hit   = 1'b0;
    run_mode      = 1'b0;
    md_allowed    = 1'b0;

    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_next   = RUN;
    end else begin
      case (state)
        RUN: begin
          run_mode   = 1'b1;
          md_allowed = 1'b1;
        end
        MD_WAIT: begin
          if (md_done) begin
            run_mode   = 1'b1;
            state_next = RUN;
          end else if (wait_cnt == WW'(MD_TIMEOUT)) begin
            // Forced release behaves exactly like a normal completion
            timeout_hit = 1'b1;
            run_mode    = 1'b1;
            state_next  = RUN;
          end else begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            wait_cnt_next = wait_cnt + WW'(1);
          end
        end
        default: state_next = RUN;
      endcase

      if (run_mode) begin
        if (ex_branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (md_allowed && ex_md_valid) begin
          md_start      = 1'b1;
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          state_next    = MD_WAIT;
          wait_cnt_next = '0;
        end else if (load_use) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_hazard_controller
// Purpose : Directed scoreboard bench for hazard_controller (MD_TIMEOUT = 3).
// Rev     : 1.0  initial release
// ============================================================================
module tb_hazard_controller;

  // Control vector order: {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_bubble, md_start}
  localparam logic [5:0] NRM = 6'b111000;
  localparam logic [5:0] RST = 6'b000110;
  localparam logic [5:0] LU  = 6'b001010;
  localparam logic [5:0] MDS = 6'b000001;
  localparam logic [5:0] WT  = 6'b000000;
  localparam logic [5:0] BR  = 6'b111110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_ex_rd = '0;
  logic        id_ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic        ex_md_valid = 1'b0, md_done = 1'b0;
  logic        pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_bubble, md_start;
  logic        md_timeout;
  logic [15:0] stall_count;

  typedef struct {
    string       nm;
    logic [5:0]  ctl;
    logic        to;
    logic [15:0] sc;
    bit          chk;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  hazard_controller #(.MD_TIMEOUT(3)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .ex_md_valid(ex_md_valid), .md_done(md_done),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .md_start(md_start),
    .md_timeout(md_timeout), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Drives one cycle of inputs and queues the expected same-cycle response
  task automatic cyc(input string nm, input logic r,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic mr, input logic br, input logic mdv, input logic mdd,
                     input logic [5:0] ctl, input logic to, input logic [15:0] sc,
                     input bit chk);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_rs1 = rs1; id_rs2 = rs2; id_ex_rd = rd;
    id_ex_mem_read = mr; ex_branch_taken = br; ex_md_valid = mdv; md_done = mdd;
    e.nm = nm; e.ctl = ctl; e.to = to; e.sc = sc; e.chk = chk;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          n_assert++;
          act = {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_bubble, md_start};
          if (act !== e.ctl || md_timeout !== e.to || stall_count !== e.sc) begin
            n_fail++;
            $display("FAIL %s: got ctl=%b to=%b sc=%h, expected ctl=%b to=%b sc=%h",
                     e.nm, act, md_timeout, stall_count, e.ctl, e.to, e.sc);
          end
        end
      end
    end
  end

  initial begin : stim
    //   name          rst rs1  rs2  rd   mr br mdv mdd ctl  to sc       chk
    cyc("rst_first",   1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, RST, 0, 16'd0,  0);
    cyc("rst_hold",    1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, RST, 0, 16'd0,  1);
    cyc("idle",        0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NRM, 0, 16'd0,  1);
    cyc("lu_rs2",      0, 5'd0, 5'd5, 5'd5, 1, 0, 0, 0, LU,  0, 16'd0,  1);
    cyc("lu_after",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NRM, 0, 16'd1,  1);
    cyc("lu_x0",       0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, NRM, 0, 16'd1,  1);
    cyc("load_nomatch",0, 5'd3, 5'd4, 5'd7, 1, 0, 0, 0, NRM, 0, 16'd1,  1);
    cyc("lu_rs1",      0, 5'd7, 5'd4, 5'd7, 1, 0, 0, 0, LU,  0, 16'd1,  1);
    cyc("lu_rs1_after",0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NRM, 0, 16'd2,  1);
    // MUL/DIV completing four cycles after start
    cyc("md_start",    0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, MDS, 0, 16'd2,  1);
    cyc("md_wait1",    0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, WT,  0, 16'd3,  1);
    cyc("md_wait_ign", 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, WT,  0, 16'd4,  1);
    cyc("md_wait3",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, WT,  0, 16'd5,  1);
    cyc("md_done",     0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, NRM, 0, 16'd6,  1);
    cyc("done_in_run", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, NRM, 0, 16'd6,  1);
    // Branch priority
    cyc("br_md",       0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, BR,  0, 16'd6,  1);
    cyc("br_md_after", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NRM, 0, 16'd6,  1);
    cyc("br_lu",       0, 5'd5, 5'd0, 5'd5, 1, 1, 0, 0, BR,  0, 16'd6,  1);
    cyc("br_lu_after", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NRM, 0, 16'd6,  1);
    // Release by md_done still evaluates load-use
    cyc("md_start2",   0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, MDS, 0, 16'd6,  1);
    cyc("done_lu",     0, 5'd5, 5'd0, 5'd5, 1, 0, 0, 1, LU,  0, 16'd7,  1);
    cyc("done_lu_aft", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NRM, 0, 16'd8,  1);
    // Timeout with MD_TIMEOUT = 3
    cyc("to_start",    0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, MDS, 0, 16'd8,  1);
    cyc("to_wait0",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, WT,  0, 16'd9,  1);
    cyc("to_wait1",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, WT,  0, 16'd10, 1);
    cyc("to_wait2",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, WT,  0, 16'd11, 1);
    cyc("to_release",  0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NRM, 0, 16'd12, 1);
    cyc("to_sticky1",  0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NRM, 1, 16'd12, 1);
    cyc("to_sticky2",  0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NRM, 1, 16'd12, 1);
    // Reset in the middle of a wait
    cyc("rw_start",    0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, MDS, 1, 16'd12, 1);
    cyc("rw_wait",     0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, WT,  1, 16'd13, 1);
    cyc("rw_reset",    1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, RST, 1, 16'd14, 1);
    cyc("rw_done_ign", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, NRM, 0, 16'd0,  1);
    cyc("rw_idle",     0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NRM, 0, 16'd0,  1);
    // Saturation: continuous load-use stall
    for (int i = 0; i < 65540; i++) begin
      cyc("sat", 0, 5'd0, 5'd5, 5'd5, 1, 0, 0, 0, LU, 0,
          (i > 65535) ? 16'hFFFF : i[15:0],
          (i == 0) || (i == 1) || (i == 65534) || (i == 65535) || (i == 65539));
    end
    cyc("sat_hold",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NRM, 0, 16'hFFFF, 1);
    cyc("sat_rst",     1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, RST, 0, 16'hFFFF, 1);
    cyc("sat_cleared", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NRM, 0, 16'd0,    1);

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left in scoreboard, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
